ubus_arbiter_n: RTL
===================

Name: ubus_arbiter_n

Overview:
- Parametrised UBUS bus controller and arbiter for NUM_MASTERS masters.
- Generates the ubus_start phase, arbitrates requests with fixed or round-robin priority, and drives read/write low during no-op cycles.
- Tracks data-phase completion and aborts hung transfers with a timeout.
- Sits beside the UBUS interface as the bus-owning DUT in UBUS environments with more than two masters.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- ROUND_ROBIN, 1, 1 = rotating priority after each grant; 0 = fixed priority, lowest index wins.
- TIMEOUT_CYCLES, 16, maximum data-phase cycles before abort; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- ubus_clock  input  1  bus clock; all logic on the rising edge.
- ubus_reset  input  1  reset; synchronous, active-high.
- ubus_req  input  NUM_MASTERS  request per master.
- ubus_gnt  output  NUM_MASTERS  one-hot grant, registered.
- ubus_start  output  1  start-phase strobe, registered.
- ubus_read  output  1  driven 0 in no-op cycles, otherwise high-Z.
- ubus_write  output  1  driven 0 in no-op cycles, otherwise high-Z.
- ubus_bip  input  1  burst in progress.
- ubus_wait  input  1  slave wait.
- ubus_error  input  1  slave error.
- gnt_idx  output  $clog2(NUM_MASTERS)  index of the last granted master.
- timeout_err  output  1  one-cycle pulse when a data phase is aborted.

Behaviour:
- Reset (synchronous, wins over everything, including mid-transfer):
  - state=S_RESET; ubus_start=0; ubus_gnt=0; ubus_read/ubus_write=Z; timeout_err=0; gnt_idx=0.
  - RR pointer=NUM_MASTERS-1, so master 0 has highest priority first.
- States:
  - S_RESET -> S_START.
  - S_START (ubus_start=1 for exactly this one cycle). At the exit edge, the picker is evaluated on sampled ubus_req.
    - Any request: load ubus_gnt one-hot, update gnt_idx, go to S_ADDR.
    - No request: ubus_gnt=0, go to S_NOOP.
  - S_NOOP: ubus_read=ubus_write=0 for this cycle only -> S_START.
  - S_ADDR: one cycle; ubus_gnt cleared at its exit edge (grant is visible exactly one cycle) -> S_DATA; timeout counter cleared.
  - S_DATA: transfer completes when ubus_error=1 or (ubus_bip=0 and ubus_wait=0) is sampled -> S_START. Otherwise stay and increment the counter.
    - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without completion: pulse timeout_err for 1 cycle, go to S_START.
    - Completion and timeout on the same edge: completion wins, no timeout_err.
- Latency:
  - Request sampled in the S_START cycle -> grant high the next cycle.
  - Minimum transfer is 3 cycles: START, ADDR, one DATA.
  - Idle bus repeats START/NOOP (period 2).
- Arbitration:
  - Fixed mode: lowest set index of ubus_req.
  - RR mode: search starts at pointer+1 modulo NUM_MASTERS, wrapping past NUM_MASTERS-1 to 0. The pointer is updated to the granted index only when a grant is issued.
  - A request deasserted before S_START is not granted. Requests during non-START states are ignored.
- ubus_read/ubus_write are never driven 1; they are Z in every state except S_NOOP.
- ubus_gnt is never multi-hot. gnt_idx holds its value when no grant is issued.

Decomposition:
- Package ubus_arb_pkg:
  - state enum: S_RESET, S_START, S_ADDR, S_DATA, S_NOOP (3 bits).
  - function onehot_to_idx.
- Sub-module ubus_rr_picker: combinational; inputs are req and pointer, outputs are one-hot gnt and valid.
  - Fixed priority is implemented as pointer tied to NUM_MASTERS-1 when ROUND_ROBIN=0.

Test Plan:
- Reset mid-S_DATA with master 2 granted -> next edge: ubus_start=0, ubus_gnt=0, read/write=Z. Then S_START one cycle after reset deasserts.
- No requests for 10 cycles -> ubus_start toggles 1,0,1,0,… and read/write=0 exactly in the cycles where ubus_start=0.
- RR, NUM_MASTERS=4, req=4'b1111 held -> successive grants 0001, 0010, 0100, 1000, 0001; gnt_idx 0,1,2,3,0. Same stimulus with ROUND_ROBIN=0 -> always 0001.
- RR, pointer at master 3, req=4'b0101 -> grant 0001 (wrap); next START with the same req -> 0100.
- TIMEOUT_CYCLES=4, ubus_bip held 1 after grant -> timeout_err pulses on the 4th DATA cycle, then ubus_start=1. Completion on that same edge -> no pulse.
- ubus_error=1 on the first DATA cycle -> S_START on the next edge, timeout_err=0.

Source files
------------

// File: rtl/ubus_arb_pkg.sv
// Shared types for the UBUS multi-master arbiter: bus-phase FSM encoding and grant index helper.
// No timing of its own; no backpressure.
package ubus_arb_pkg;

   typedef enum logic [2:0] {
      S_RESET,
      S_START,
      S_ADDR,
      S_DATA,
      S_NOOP
   } state_t;

   // Supports up to 16 masters; callers zero-extend narrower grant vectors.
   function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ubus_rr_picker.sv
// Combinational priority picker: first requester strictly after ptr, wrapping to 0.
// Zero latency; no backpressure (pure function of req and ptr).
module ubus_rr_picker
   import ubus_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          vld
);

   // Two passes: indices above ptr first, then the wrapped range 0..ptr.
   always_comb begin
      gnt = '0;
      vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!vld && req[i] && (i > int'(ptr))) begin
            gnt[i] = 1'b1;
            vld    = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!vld && req[i] && (i <= int'(ptr))) begin
            gnt[i] = 1'b1;
            vld    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ubus_arbiter_n.sv
// UBUS bus controller/arbiter: START phase, fixed or round-robin grant, NOOP drive, data-phase timeout.
// Grant is registered one cycle after the START sample; slaves stall via ubus_wait/ubus_bip up to TIMEOUT_CYCLES.
module ubus_arbiter_n
   import ubus_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int ROUND_ROBIN    = 1,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic                           ubus_clock,
   input  logic                           ubus_reset,
   input  logic [NUM_MASTERS-1:0]         ubus_req,
   output logic [NUM_MASTERS-1:0]         ubus_gnt,
   output logic                           ubus_start,
   output wire logic                      ubus_read,
   output wire logic                      ubus_write,
   input  logic                           ubus_bip,
   input  logic                           ubus_wait,
   input  logic                           ubus_error,
   output logic [$clog2(NUM_MASTERS)-1:0] gnt_idx,
   output logic                           timeout_err
);

   localparam int IW = $clog2(NUM_MASTERS);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t                 state, next_state;
   logic [IW-1:0]          rr_ptr, pick_ptr, pick_idx;
   logic [NUM_MASTERS-1:0] pick_gnt, gnt_d;
   logic                   pick_vld, ld_idx, terr_d, noop_q;
   logic [CNT_W-1:0]       cnt, cnt_d;

   // Fixed priority is the round-robin picker with the pointer parked on the top index.
   assign pick_ptr = (ROUND_ROBIN != 0) ? rr_ptr : IW'(NUM_MASTERS - 1);
   assign pick_idx = IW'(onehot_to_idx(16'(pick_gnt)));

   ubus_rr_picker #(
      .N  (NUM_MASTERS),
      .IW (IW)
   ) u_picker (
      .req (ubus_req),
      .ptr (pick_ptr),
      .gnt (pick_gnt),
      .vld (pick_vld)
   );

   always_comb begin
      next_state = state;
      gnt_d      = '0;
      ld_idx     = 1'b0;
      terr_d     = 1'b0;
      cnt_d      = cnt;
      case (state)
         S_RESET: next_state = S_START;
         S_START: begin
            if (pick_vld) begin
               next_state = S_ADDR;
               gnt_d      = pick_gnt;
               ld_idx     = 1'b1;
            end else begin
               next_state = S_NOOP;
            end
         end
         S_NOOP:  next_state = S_START;
         S_ADDR: begin
            next_state = S_DATA;
            cnt_d      = '0;
         end
         S_DATA: begin
            // Completion is checked first so it beats a coincident timeout.
            if (ubus_error || (!ubus_bip && !ubus_wait)) begin
               next_state = S_START;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
               next_state = S_START;
               terr_d     = 1'b1;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: next_state = S_RESET;
      endcase
   end

   always_ff @(posedge ubus_clock) begin
      if (ubus_reset) begin
         state       <= S_RESET;
         ubus_start  <= 1'b0;
         ubus_gnt    <= '0;
         noop_q      <= 1'b0;
         timeout_err <= 1'b0;
         gnt_idx     <= '0;
         rr_ptr      <= IW'(NUM_MASTERS - 1);
         cnt         <= '0;
      end else begin
         state       <= next_state;
         ubus_start  <= (next_state == S_START);
         ubus_gnt    <= gnt_d;
         noop_q      <= (next_state == S_NOOP);
         timeout_err <= terr_d;
         cnt         <= cnt_d;
         if (ld_idx) begin
            gnt_idx <= pick_idx;
            rr_ptr  <= pick_idx;
         end
      end
   end

   assign ubus_read  = noop_q ? 1'b0 : 1'bz;
   assign ubus_write = noop_q ? 1'b0 : 1'bz;

endmodule
